// File: rtl/mest_pro_run_checker_if.sv
// mest_pro_run_checker_if: link between the run checker (master) and the mest_pro DUT (slave)
interface mest_pro_run_checker_if #(parameter int RESULT_WIDTH = 8);
  logic o_reset_n;
  logic o_memory_reset;
  logic o_start;
  logic [RESULT_WIDTH-1:0] i_result;
  logic i_valid_result;
  logic i_carry;
  logic i_zero_flag;
  logic i_all_done;
  modport master (
    output o_reset_n, o_memory_reset, o_start,
    input  i_result, i_valid_result, i_carry, i_zero_flag, i_all_done
  );
  modport slave (
    input  o_reset_n, o_memory_reset, o_start,
    output i_result, i_valid_result, i_carry, i_zero_flag, i_all_done
  );
endinterface

// File: rtl/mest_pro_run_checker.sv
// mest_pro_run_checker: sequences NUM_RUNS mest_pro runs and scores every result against a loadable expected buffer
// Ports: clk, i_reset (sync, active-high); i_go starts a campaign; i_exp_clr/i_exp_wr/i_exp_data ({carry, zero, result}) load the buffer, o_exp_full;
// io_dut drives DUT reset/memory reset/start and observes result/valid/flags/all_done; o_busy, o_done, o_pass, o_err_count, o_run_idx, o_timeout report status.
module mest_pro_run_checker #(
  parameter int RESULT_WIDTH   = 8,
  parameter int EXP_DEPTH      = 16,
  parameter int NUM_RUNS       = 4,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                               clk,
  input  logic                               i_reset,
  input  logic                               i_go,
  input  logic                               i_exp_clr,
  input  logic                               i_exp_wr,
  input  logic [RESULT_WIDTH+1:0]            i_exp_data,
  output logic                               o_exp_full,
  mest_pro_run_checker_if.master             io_dut,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_pass,
  output logic [15:0]                        o_err_count,
  output logic [$clog2(NUM_RUNS+1)-1:0]      o_run_idx,
  output logic                               o_timeout
);
  localparam int AW = $clog2(EXP_DEPTH);
  localparam int CW = $clog2(EXP_DEPTH + 1);
  localparam int RW = $clog2(NUM_RUNS + 1);
  localparam int KW = $clog2(RESET_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_MEMRST, S_RELEASE, S_START, S_RUN, S_NEXT, S_DONE} state_t;
  state_t r_state;
  logic [RESULT_WIDTH+1:0] r_exp [EXP_DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rptr;
  logic [KW-1:0] r_rcnt;
  logic [WW-1:0] r_wdog;
  logic w_idle;
  logic w_wr;
  logic w_hit;
  logic w_bad;
  logic w_missing;
  logic w_wdog_exp;
  logic w_err_inc;
  logic [CW-1:0] w_rptr;
  always_comb begin
    w_idle     = r_state == S_IDLE || r_state == S_DONE;
    w_wr       = w_idle && i_exp_wr && !i_exp_clr && r_cnt != CW'(EXP_DEPTH);
    w_hit      = io_dut.i_valid_result && r_rptr < r_cnt;
    w_bad      = io_dut.i_valid_result && (r_rptr >= r_cnt ||
                 {io_dut.i_carry, io_dut.i_zero_flag, io_dut.i_result} != r_exp[r_rptr[AW-1:0]]);
    w_rptr     = r_rptr + CW'(w_hit);
    w_missing  = io_dut.i_all_done && w_rptr < r_cnt;
    w_wdog_exp = !io_dut.i_all_done && r_wdog == WW'(TIMEOUT_CYCLES - 1);
    w_err_inc  = r_state == S_RUN && (w_bad || w_missing || w_wdog_exp);
  end
  always_ff @(posedge clk) if (w_wr) r_exp[r_cnt[AW-1:0]] <= i_exp_data;
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state               <= S_IDLE;
      r_cnt                 <= '0;
      r_rptr                <= '0;
      r_rcnt                <= '0;
      r_wdog                <= '0;
      o_exp_full            <= 1'b0;
      io_dut.o_reset_n      <= 1'b0;
      io_dut.o_memory_reset <= 1'b0;
      io_dut.o_start        <= 1'b0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_pass                <= 1'b0;
      o_err_count           <= '0;
      o_run_idx             <= '0;
      o_timeout             <= 1'b0;
    end else begin
      io_dut.o_reset_n      <= r_state inside {S_RELEASE, S_START, S_RUN};
      io_dut.o_memory_reset <= r_state == S_MEMRST;
      io_dut.o_start        <= r_state == S_START;
      if (w_idle && i_exp_clr) begin
        r_cnt      <= '0;
        o_exp_full <= 1'b0;
      end else if (w_wr) begin
        r_cnt      <= r_cnt + CW'(1);
        o_exp_full <= r_cnt == CW'(EXP_DEPTH - 1);
      end
      if (w_err_inc && o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
      case (r_state)
        S_IDLE, S_DONE: if (i_go) begin
          r_state     <= S_MEMRST;
          r_rcnt      <= '0;
          o_err_count <= '0;
          o_timeout   <= 1'b0;
          o_run_idx   <= '0;
          o_busy      <= 1'b1;
          o_done      <= 1'b0;
          o_pass      <= 1'b0;
        end
        S_MEMRST: if (r_rcnt == KW'(RESET_CYCLES - 1)) r_state <= S_RELEASE; else r_rcnt <= r_rcnt + KW'(1);
        S_RELEASE: r_state <= S_START;
        S_START: begin
          r_state <= S_RUN;
          r_rptr  <= '0;
          r_wdog  <= '0;
        end
        S_RUN: begin
          r_rptr <= w_rptr;
          r_wdog <= r_wdog + WW'(1);
          if (w_wdog_exp) o_timeout <= 1'b1;
          if (io_dut.i_all_done || w_wdog_exp) r_state <= S_NEXT;
        end
        S_NEXT: begin
          o_run_idx <= o_run_idx + RW'(1);
          r_rcnt    <= '0;
          if (o_run_idx == RW'(NUM_RUNS - 1)) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_pass  <= o_err_count == '0 && !o_timeout;
          end else r_state <= S_MEMRST;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mest_pro_run_checker.sv
// tb_mest_pro_run_checker: scoreboard bench for mest_pro_run_checker with a behavioural mest_pro stand-in
module tb_mest_pro_run_checker;
  logic clk = 1'b0;
  logic i_reset, i_go, i_exp_clr, i_exp_wr;
  logic [9:0] i_exp_data;
  logic o_exp_full, o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_err_count;
  logic [1:0] o_run_idx;
  int n_chk = 0;
  int n_err = 0;
  logic [9:0] tb_buf[$];
  int exp_q[$];
  int p_nres[2];
  int p_bad[2];
  bit p_same, p_hang, p_gowr, p_busywr;
  logic [9:0] p_gowr_data;
  mest_pro_run_checker_if #(.RESULT_WIDTH(8)) io();
  mest_pro_run_checker #(
    .RESULT_WIDTH(8), .EXP_DEPTH(16), .NUM_RUNS(2), .RESET_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_go(i_go), .i_exp_clr(i_exp_clr), .i_exp_wr(i_exp_wr),
    .i_exp_data(i_exp_data), .o_exp_full(o_exp_full), .io_dut(io.master), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count), .o_run_idx(o_run_idx),
    .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic wr(input logic [9:0] d);
    @(posedge clk); #1;
    i_exp_wr = 1'b1;
    i_exp_data = d;
    @(posedge clk); #1;
    i_exp_wr = 1'b0;
    if (tb_buf.size() < 16) tb_buf.push_back(d);
  endtask
  task automatic plan(input int n0, input int n1, input int b0, input int b1, input bit s, input bit h);
    p_nres[0] = n0;
    p_nres[1] = n1;
    p_bad[0] = b0;
    p_bad[1] = b1;
    p_same = s;
    p_hang = h;
  endtask
  task automatic campaign(input string tag);
    int m_err, p, mr, gap, t, n, inc;
    bit m_to, same;
    logic [9:0] d;
    m_err = 0;
    m_to = 0;
    @(posedge clk); #1;
    i_go = 1'b1;
    if (p_gowr) begin
      i_exp_wr = 1'b1;
      i_exp_data = p_gowr_data;
      if (tb_buf.size() < 16) tb_buf.push_back(p_gowr_data);
    end
    @(posedge clk); #1;
    i_go = 1'b0;
    i_exp_wr = 1'b0;
    for (int r = 0; r < 2; r++) begin
      mr = 0; gap = 0; t = 0;
      while (1) begin
        @(negedge clk);
        if (p_busywr) begin
          i_exp_wr = (t == 0);
          i_exp_data = 10'h3ff;
        end
        if (io.o_memory_reset) begin mr++; gap = 0; end else gap++;
        if (io.o_start || t > 100) break;
        t++;
      end
      i_exp_wr = 1'b0;
      check($sformatf("%s_r%0d_start", tag, r), io.o_start, 1);
      check($sformatf("%s_r%0d_memrst_cycles", tag, r), mr, 4);
      check($sformatf("%s_r%0d_start_gap", tag, r), gap, 2);
      check($sformatf("%s_r%0d_reset_n", tag, r), io.o_reset_n, 1);
      p = 0;
      n = p_nres[r];
      same = p_same && n > 0;
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        if (i > 0) check($sformatf("%s_r%0d_err_i%0d", tag, r, i - 1), o_err_count, exp_q.pop_front());
        d = (i < tb_buf.size()) ? tb_buf[i] : 10'h2aa;
        if (i == p_bad[r]) d[0] = ~d[0];
        io.i_valid_result = 1'b1;
        {io.i_carry, io.i_zero_flag, io.i_result} = d;
        io.i_all_done = same && i == n - 1;
        inc = 0;
        if (p < tb_buf.size()) begin
          inc = int'(d != tb_buf[p]);
          p++;
        end else inc = 1;
        if (io.i_all_done && p < tb_buf.size()) inc = 1;
        m_err += inc;
        exp_q.push_back(m_err);
      end
      @(posedge clk); #1;
      if (n > 0) check($sformatf("%s_r%0d_err_last", tag, r), o_err_count, exp_q.pop_front());
      io.i_valid_result = 1'b0;
      io.i_all_done = 1'b0;
      if (p_hang) begin
        t = 0;
        while (o_run_idx == 2'(r) && t < 60) begin @(posedge clk); #1; t++; end
        m_err++;
        m_to = 1;
        exp_q.push_back(m_err);
        check($sformatf("%s_r%0d_err_wdog", tag, r), o_err_count, exp_q.pop_front());
        check($sformatf("%s_r%0d_timeout", tag, r), o_timeout, 1);
      end else begin
        if (!same) begin
          io.i_all_done = 1'b1;
          m_err += int'(p < tb_buf.size());
          exp_q.push_back(m_err);
          @(posedge clk); #1;
          io.i_all_done = 1'b0;
          check($sformatf("%s_r%0d_err_done", tag, r), o_err_count, exp_q.pop_front());
        end
        @(posedge clk); #1;
      end
      check($sformatf("%s_r%0d_run_idx", tag, r), o_run_idx, r + 1);
    end
    t = 0;
    while (!o_done && t < 20) begin @(negedge clk); t++; end
    check({tag, "_done"}, o_done, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_pass"}, o_pass, (m_err == 0 && !m_to) ? 1 : 0);
    check({tag, "_err_final"}, o_err_count, m_err);
    check({tag, "_run_idx_final"}, o_run_idx, 2);
    check({tag, "_timeout_final"}, o_timeout, m_to);
    check({tag, "_reset_n_done"}, io.o_reset_n, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
  initial begin
    int t;
    i_reset = 1'b1; i_go = 1'b0; i_exp_clr = 1'b0; i_exp_wr = 1'b0; i_exp_data = '0;
    io.i_result = '0; io.i_valid_result = 1'b0; io.i_carry = 1'b0; io.i_zero_flag = 1'b0; io.i_all_done = 1'b0;
    p_gowr = 0; p_busywr = 0; p_gowr_data = '0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("reset_flags", {io.o_reset_n, io.o_memory_reset, io.o_start, o_busy, o_done, o_pass, o_timeout, o_exp_full}, 8'h00);
    check("reset_err", o_err_count, 0);
    check("reset_run_idx", o_run_idx, 0);
    wr(10'h005);
    wr(10'h200);
    p_gowr = 1;
    p_gowr_data = 10'h100;
    plan(3, 3, -1, -1, 0, 0);
    campaign("clean");
    p_gowr = 0;
    plan(3, 3, 1, -1, 0, 0);
    campaign("mismatch");
    plan(4, 2, -1, -1, 0, 0);
    campaign("extra_missing");
    plan(3, 3, -1, -1, 1, 0);
    campaign("same_cycle");
    plan(3, 3, -1, -1, 0, 1);
    campaign("watchdog");
    @(posedge clk); #1 i_exp_clr = 1'b1;
    @(posedge clk); #1 i_exp_clr = 1'b0;
    tb_buf.delete();
    for (int i = 0; i < 17; i++) begin
      wr(10'(i * 7));
      if (i >= 14) check($sformatf("full_after_%0d", i + 1), o_exp_full, tb_buf.size() == 16);
    end
    @(posedge clk); #1 i_go = 1'b1;
    @(posedge clk); #1 i_go = 1'b0;
    t = 0;
    while (!io.o_start && t < 50) begin @(negedge clk); t++; end
    check("midrst_start_seen", io.o_start, 1);
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    tb_buf.delete();
    @(negedge clk);
    check("midrst_flags", {io.o_reset_n, io.o_memory_reset, io.o_start, o_busy, o_done, o_pass, o_timeout, o_exp_full}, 8'h00);
    check("midrst_err", o_err_count, 0);
    check("midrst_run_idx", o_run_idx, 0);
    wr(10'h0aa);
    @(posedge clk); #1;
    i_exp_clr = 1'b1;
    i_exp_wr = 1'b1;
    i_exp_data = 10'h055;
    @(posedge clk); #1;
    i_exp_clr = 1'b0;
    i_exp_wr = 1'b0;
    tb_buf.delete();
    check("clr_wr_full", o_exp_full, 0);
    p_busywr = 1;
    plan(0, 0, -1, -1, 0, 0);
    campaign("empty_buf");
    p_busywr = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
